// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down bounce counter family.
package updown_pkg;

  // Sequencer states: two stepping states plus a dwell state at each bound.
  typedef enum logic [1:0] {
    S_UP       = 2'd0,
    S_DOWN     = 2'd1,
    S_DWELL_HI = 2'd2,
    S_DWELL_LO = 2'd3
  } state_t;

  localparam logic MODE_BOUNCE = 1'b0;
  localparam logic MODE_WRAP   = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Dwell counter width; DWELL is limited to 0..255.
  localparam int unsigned DWELL_W = 8;

endpackage

// File: rtl/updown_step.sv
// Combinational next-count for one step: clamp-and-reverse in bounce mode,
// modular wraparound in wrap mode. hit_o flags a bound reversal (bounce)
// or a wraparound (wrap).
module updown_step
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MIN   = 0,
  parameter int unsigned MAX   = 15,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             dir_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             hit_o
);

  // One guard bit so count+STEP cannot overflow before the bound checks.
  localparam int unsigned EW = WIDTH + 1;
  localparam logic [EW-1:0] MIN_E  = EW'(MIN);
  localparam logic [EW-1:0] MAX_E  = EW'(MAX);
  localparam logic [EW-1:0] STEP_E = EW'(STEP);
  localparam logic [EW-1:0] ONE_E  = EW'(1);

  logic [EW-1:0] cur_e;
  logic [EW-1:0] up_e;
  logic [EW-1:0] dn_e;
  logic [EW-1:0] next_e;

  assign cur_e = {1'b0, count_i};
  assign up_e  = cur_e + STEP_E;
  assign dn_e  = cur_e - STEP_E;

  // Select the stepped value by mode and direction.
  always_comb begin
    next_e = cur_e;
    hit_o  = 1'b0;
    if (mode_i == MODE_WRAP) begin
      if (dir_i == DIR_UP) begin
        if (up_e > MAX_E) begin
          next_e = MIN_E + (up_e - MAX_E - ONE_E);
          hit_o  = 1'b1;
        end else begin
          next_e = up_e;
        end
      end else begin
        if (cur_e < MIN_E + STEP_E) begin
          next_e = MAX_E - (MIN_E + STEP_E - cur_e - ONE_E);
          hit_o  = 1'b1;
        end else begin
          next_e = dn_e;
        end
      end
    end else begin
      if (dir_i == DIR_UP) begin
        if (cur_e >= MAX_E) begin
          // Already at the top: the reversed step.
          next_e = MAX_E - STEP_E;
          hit_o  = 1'b1;
        end else if (up_e > MAX_E) begin
          next_e = MAX_E;
        end else begin
          next_e = up_e;
        end
      end else begin
        if (cur_e == MIN_E) begin
          next_e = MIN_E + STEP_E;
          hit_o  = 1'b1;
        end else if (cur_e < MIN_E + STEP_E) begin
          next_e = MIN_E;
        end else begin
          next_e = dn_e;
        end
      end
    end
  end

  assign next_o = WIDTH'(next_e);

endmodule

// File: rtl/updown_bounce_counter.sv
// Parametrised up/down counter: bounce mode with optional dwell at the
// bounds, or wrap mode with externally requested direction.
module updown_bounce_counter
  import updown_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MIN   = 0,
  parameter int unsigned MAX   = 15,
  parameter int unsigned STEP  = 1,
  parameter int unsigned DWELL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir_req,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             at_min,
  output logic             at_max,
  output logic             turn,
  output logic             wrap
);

  localparam int unsigned   EW         = WIDTH + 1;
  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX);
  localparam logic [EW-1:0] MIN_E      = EW'(MIN);
  localparam logic [EW-1:0] MAX_E      = EW'(MAX);
  localparam bit            HAS_DWELL  = (DWELL != 0);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 dir_q, dir_d;
  logic                 turn_q, turn_d;
  logic                 wrap_q, wrap_d;

  logic                 step_dir;
  logic [WIDTH-1:0]     step_next;
  logic                 step_hit;
  logic [EW-1:0]        load_e;
  logic [EW-1:0]        lo_diff;
  logic [EW-1:0]        hi_diff;
  logic [WIDTH-1:0]     load_clamped;

  // Wrap mode steps in the requested direction; bounce follows the state.
  assign step_dir = (mode == MODE_WRAP) ? dir_req : dir_q;

  updown_step #(
    .WIDTH (WIDTH),
    .MIN   (MIN),
    .MAX   (MAX),
    .STEP  (STEP)
  ) u_step (
    .count_i (count_q),
    .dir_i   (step_dir),
    .mode_i  (mode),
    .next_o  (step_next),
    .hit_o   (step_hit)
  );

  // Clamp the load value; sign bit of the guarded difference gives the compare.
  assign load_e       = {1'b0, load_val};
  assign lo_diff      = load_e - MIN_E;
  assign hi_diff      = MAX_E - load_e;
  assign load_clamped = lo_diff[EW-1] ? MIN_W :
                        hi_diff[EW-1] ? MAX_W : load_val;

  // Next-state logic: load beats enable, enable beats hold.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dwell_d = dwell_q;
    dir_d   = dir_q;
    turn_d  = 1'b0;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_clamped;
      dwell_d = '0;
      if (mode == MODE_WRAP && dir_req == DIR_DOWN) begin
        state_d = S_DOWN;
        dir_d   = DIR_DOWN;
      end else begin
        state_d = S_UP;
        dir_d   = DIR_UP;
      end
    end else if (en) begin
      if (mode == MODE_WRAP) begin
        state_d = (dir_req == DIR_DOWN) ? S_DOWN : S_UP;
        dir_d   = dir_req;
        count_d = step_next;
        wrap_d  = step_hit;
        dwell_d = '0;
      end else begin
        case (state_q)
          S_UP: begin
            if (step_hit) begin
              dir_d  = DIR_DOWN;
              turn_d = 1'b1;
              if (HAS_DWELL) begin
                state_d = S_DWELL_HI;
                dwell_d = '0;
              end else begin
                state_d = S_DOWN;
                count_d = step_next;
              end
            end else begin
              count_d = step_next;
            end
          end
          S_DOWN: begin
            if (step_hit) begin
              dir_d  = DIR_UP;
              turn_d = 1'b1;
              if (HAS_DWELL) begin
                state_d = S_DWELL_LO;
                dwell_d = '0;
              end else begin
                state_d = S_UP;
                count_d = step_next;
              end
            end else begin
              count_d = step_next;
            end
          end
          S_DWELL_HI: begin
            if (dwell_q == DWELL_LAST) begin
              state_d = S_DOWN;
              count_d = step_next;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + DWELL_W'(1);
            end
          end
          default: begin
            if (dwell_q == DWELL_LAST) begin
              state_d = S_UP;
              count_d = step_next;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + DWELL_W'(1);
            end
          end
        endcase
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_UP;
      count_q <= MIN_W;
      dwell_q <= '0;
      dir_q   <= DIR_UP;
      turn_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dwell_q <= dwell_d;
      dir_q   <= dir_d;
      turn_q  <= turn_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count  = count_q;
  assign dir    = dir_q;
  assign turn   = turn_q;
  assign wrap   = wrap_q;
  assign at_min = (count_q == MIN_W);
  assign at_max = (count_q == MAX_W);

endmodule
